slc_arb: RTL and testbench

SLC_ARB -- requirements
Module: slc_arb

---
 rtl/slc_arb.sv | 148 ++++++++++++++
 tb/tb_slc_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/slc_arb.sv
// slc_arb: arbitrates RXREQ and RXRSP POSQ heads into a one-entry output slot
// that feeds the SLC/SF pipeline. Responses win over requests. Requests are
// blocked while the POCQ is full.
// Optional feature macro: SLC_ARB_STARVE_EN. When it is defined, a starvation
// counter forces a request grant after STARVE_LIMIT consecutive response
// grants that happen while a request was eligible.

package slc_arb_pkg;
    typedef struct packed {
        logic [7:0]  txnid;
        logic [5:0]  opcode;
        logic [31:0] addr;
    } reqflit_t;

    typedef struct packed {
        logic [7:0] txnid;
        logic [3:0] opcode;
        logic [7:0] dbid;
    } rspflit_t;
endpackage

module slc_arb
    import slc_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     req_valid,
    output logic     req_ready,
    input  reqflit_t req_flit,
    input  logic     rsp_valid,
    output logic     rsp_ready,
    input  rspflit_t rsp_flit,
    input  logic     pocq_full,
    output logic     slc_valid,
    input  logic     slc_ready,
    output logic     slc_is_rsp,
    output reqflit_t slc_req_flit,
    output rspflit_t slc_rsp_flit
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL_REQ = 2'd1,
        FULL_RSP = 2'd2
    } state_e;

    state_e   state_q, state_d;
    logic     slc_valid_q, slc_valid_d;
    logic     slc_is_rsp_q, slc_is_rsp_d;
    reqflit_t req_flit_q, req_flit_d;
    rspflit_t rsp_flit_q, rsp_flit_d;

    logic slot_free;
    logic req_eligible;
    logic starve_force;
    logic grant_rsp;
    logic grant_req;

`ifdef SLC_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Force a request once responses have won STARVE_LIMIT times in a row.
    assign starve_force = (starve_cnt_q >= 4'(STARVE_LIMIT));

    // Count response wins while a request is eligible. Clear when a request is
    // granted or no request is eligible. Saturate at 15.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_req || !req_eligible) begin
            starve_cnt_d = 4'd0;
        end else if (grant_rsp && (starve_cnt_q != 4'd15)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // There is no counter. Only an illegal limit below 1 could force a request,
    // so with a legal limit responses always win.
    assign starve_force = (STARVE_LIMIT < 1);
`endif

    assign slot_free    = (state_q == EMPTY) | slc_ready;
    assign req_eligible = req_valid & ~pocq_full;

    // Both grants are gated by reset. A flit is never accepted while reset is held.
    assign grant_rsp = reset & slot_free & rsp_valid & ~(starve_force & req_eligible);
    assign grant_req = reset & slot_free & req_eligible & ~grant_rsp;

    assign req_ready = grant_req;
    assign rsp_ready = grant_rsp;

    // Next slot state and payload capture. A payload is loaded only on its grant.
    always_comb begin
        state_d      = state_q;
        slc_valid_d  = slc_valid_q;
        slc_is_rsp_d = slc_is_rsp_q;
        req_flit_d   = req_flit_q;
        rsp_flit_d   = rsp_flit_q;
        if (grant_rsp) begin
            state_d      = FULL_RSP;
            slc_valid_d  = 1'b1;
            slc_is_rsp_d = 1'b1;
            rsp_flit_d   = rsp_flit;
        end else if (grant_req) begin
            state_d      = FULL_REQ;
            slc_valid_d  = 1'b1;
            slc_is_rsp_d = 1'b0;
            req_flit_d   = req_flit;
        end else if (slc_ready) begin
            state_d      = EMPTY;
            slc_valid_d  = 1'b0;
            slc_is_rsp_d = 1'b0;
        end
    end

    // Slot FSM with registered outputs. Reset discards any held flit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= EMPTY;
            slc_valid_q  <= 1'b0;
            slc_is_rsp_q <= 1'b0;
            req_flit_q   <= '0;
            rsp_flit_q   <= '0;
        end else begin
            state_q      <= state_d;
            slc_valid_q  <= slc_valid_d;
            slc_is_rsp_q <= slc_is_rsp_d;
            req_flit_q   <= req_flit_d;
            rsp_flit_q   <= rsp_flit_d;
        end
    end

    assign slc_valid    = slc_valid_q;
    assign slc_is_rsp   = slc_is_rsp_q;
    assign slc_req_flit = req_flit_q;
    assign slc_rsp_flit = rsp_flit_q;

endmodule

// File: tb/tb_slc_arb.sv
// Directed bench for slc_arb. The stimulus pushes each expected slot flit into
// a queue. A forked monitor pops one entry per accepted output beat and
// compares it.
module tb_slc_arb;
    import slc_arb_pkg::*;

    logic     clock = 1'b0;
    logic     reset;
    logic     req_valid, req_ready, rsp_valid, rsp_ready;
    reqflit_t req_flit;
    rspflit_t rsp_flit;
    logic     pocq_full, slc_valid, slc_ready, slc_is_rsp;
    reqflit_t slc_req_flit;
    rspflit_t slc_rsp_flit;

    typedef struct {
        logic     is_rsp;
        reqflit_t req;
        rspflit_t rsp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    slc_arb #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flit(rsp_flit),
        .pocq_full(pocq_full),
        .slc_valid(slc_valid), .slc_ready(slc_ready), .slc_is_rsp(slc_is_rsp),
        .slc_req_flit(slc_req_flit), .slc_rsp_flit(slc_rsp_flit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic reqflit_t mkreq(input int id);
        reqflit_t r;
        r.txnid  = 8'(id);
        r.opcode = 6'(id + 3);
        r.addr   = 32'h1000_0000 + 32'(id * 64);
        return r;
    endfunction

    function automatic rspflit_t mkrsp(input int id);
        rspflit_t r;
        r.txnid  = 8'(id);
        r.opcode = 4'(id + 1);
        r.dbid   = 8'(id ^ 8'h5a);
        return r;
    endfunction

    task automatic push_req(input reqflit_t r);
        exp_t e;
        e.is_rsp = 1'b0; e.req = r; e.rsp = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_rsp(input rspflit_t r);
        exp_t e;
        e.is_rsp = 1'b1; e.req = '0; e.rsp = r;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b1; rsp_valid = 1'b1;
        req_flit = mkreq(1); rsp_flit = mkrsp(1);
        pocq_full = 1'b0; slc_ready = 1'b1;

        fork
            forever begin
                exp_t e;
                @(negedge clock);
                if (slc_valid && slc_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(slc_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_is_rsp", 64'(slc_is_rsp), 64'(e.is_rsp));
                        if (e.is_rsp) chk("out_rsp_flit", 64'(slc_rsp_flit), 64'(e.rsp));
                        else          chk("out_req_flit", 64'(slc_req_flit), 64'(e.req));
                    end
                end
            end
        join_none

        // Reset state, with both readies gated while reset is low.
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_ready", 64'(rsp_ready), 64'd0);
        cyc();
        @(negedge clock);
        chk("rst_slc_valid", 64'(slc_valid), 64'd0);
        chk("rst_is_rsp", 64'(slc_is_rsp), 64'd0);
        chk("rst_req_payload", 64'(slc_req_flit), 64'd0);
        chk("rst_rsp_payload", 64'(slc_rsp_flit), 64'd0);
        cyc();
        reset = 1'b1;

        // Request and response arrive together on an empty slot: the response wins.
        req_flit = mkreq(2); rsp_flit = mkrsp(2);
        @(negedge clock);
        chk("sim_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("sim_req_ready", 64'(req_ready), 64'd0);
        push_rsp(mkrsp(2));
        cyc();
        req_valid = 1'b0; rsp_valid = 1'b0;
        @(negedge clock);
        chk("sim_next_valid", 64'(slc_valid), 64'd1);
        chk("sim_next_is_rsp", 64'(slc_is_rsp), 64'd1);
        cyc();

        // Three back-to-back requests, one grant per cycle.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_flit = mkreq(10 + i);
            @(negedge clock);
            chk("b2b_req_ready", 64'(req_ready), 64'd1);
            if (i > 0) chk("b2b_slc_valid", 64'(slc_valid), 64'd1);
            push_req(mkreq(10 + i));
            cyc();
        end
        req_valid = 1'b0;
        @(negedge clock);
        chk("b2b_third_valid", 64'(slc_valid), 64'd1);
        cyc();
        @(negedge clock);
        chk("b2b_drained", 64'(slc_valid), 64'd0);

        // A stalled FULL_REQ slot blocks a pending response for 5 cycles.
        req_valid = 1'b1; req_flit = mkreq(20);
        push_req(mkreq(20));
        cyc();
        req_valid = 1'b0; slc_ready = 1'b0;
        rsp_valid = 1'b1; rsp_flit = mkrsp(21);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_rsp_ready", 64'(rsp_ready), 64'd0);
            chk("stall_valid", 64'(slc_valid), 64'd1);
            chk("stall_is_rsp", 64'(slc_is_rsp), 64'd0);
            chk("stall_payload", 64'(slc_req_flit), 64'(mkreq(20)));
            cyc();
        end
        slc_ready = 1'b1;
        @(negedge clock);
        chk("unstall_rsp_ready", 64'(rsp_ready), 64'd1);
        push_rsp(mkrsp(21));
        cyc();
        rsp_valid = 1'b0;
        cyc();

        // A full POCQ blocks requests, but a response can still be granted.
        pocq_full = 1'b1; req_valid = 1'b1; req_flit = mkreq(30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("pocq_req_ready", 64'(req_ready), 64'd0);
            chk("pocq_slc_valid", 64'(slc_valid), 64'd0);
            cyc();
        end
        rsp_valid = 1'b1; rsp_flit = mkrsp(31);
        @(negedge clock);
        chk("pocq_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("pocq_req_blocked", 64'(req_ready), 64'd0);
        push_rsp(mkrsp(31));
        cyc();
        rsp_valid = 1'b0;
        @(negedge clock);
        chk("pocq_req_still_blocked", 64'(req_ready), 64'd0);
        cyc();
        pocq_full = 1'b0;
        @(negedge clock);
        chk("pocq_drop_req_ready", 64'(req_ready), 64'd1);
        push_req(mkreq(30));
        cyc();
        req_valid = 1'b0;
        cyc();

        // Continuous contention: responses win, with a forced request every fifth
        // grant when starvation control is built in.
        req_valid = 1'b1; rsp_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic want_rsp;
            req_flit = mkreq(40 + k); rsp_flit = mkrsp(40 + k);
`ifdef SLC_ARB_STARVE_EN
            want_rsp = ((k % 5) != 4);
`else
            want_rsp = 1'b1;
`endif
            @(negedge clock);
            chk("starve_rsp_ready", 64'(rsp_ready), 64'(want_rsp));
            chk("starve_req_ready", 64'(req_ready), 64'(!want_rsp));
            if (want_rsp) push_rsp(mkrsp(40 + k));
            else          push_req(mkreq(40 + k));
            cyc();
        end
        req_valid = 1'b0; rsp_valid = 1'b0;
        cyc();

        // A reset while FULL_RSP discards the held flit.
        rsp_valid = 1'b1; rsp_flit = mkrsp(60);
        cyc();
        slc_ready = 1'b0; req_valid = 1'b1; req_flit = mkreq(61); rsp_flit = mkrsp(61);
        @(negedge clock);
        chk("pre_rst_is_rsp", 64'(slc_is_rsp), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_rsp_ready", 64'(rsp_ready), 64'd0);
        cyc();
        reset = 1'b1; req_valid = 1'b0; rsp_valid = 1'b0;
        @(negedge clock);
        chk("midrst_slc_valid", 64'(slc_valid), 64'd0);
        chk("midrst_is_rsp", 64'(slc_is_rsp), 64'd0);
        chk("midrst_rsp_payload", 64'(slc_rsp_flit), 64'd0);
`ifdef SLC_ARB_STARVE_EN
        chk("midrst_starve_cnt", 64'(dut.starve_cnt_q), 64'd0);
`endif
        slc_ready = 1'b1;
        cyc();
        cyc();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
